// File: rtl/komut_on_getirme.sv
// Instruction prefetch buffer: fetches sequential words over a req/ack bus into
// a small FIFO and presents the head word to the decode core.
module komut_on_getirme #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        yonlendir,
    input  logic [31:0] yeni_pc,
    input  logic        tuket,
    output logic [31:0] komut,
    output logic [31:0] komut_pc,
    output logic        komut_gecerli,
    output logic        hata,
    output logic        bellek_istek,
    output logic [31:0] bellek_adres,
    input  logic        bellek_hazir,
    input  logic [31:0] bellek_veri,
    input  logic        bellek_hata
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {BOS, BEKLE, AT} durum_t;

    typedef struct packed {
        logic [31:0] veri;
        logic [31:0] adres;
        logic        err;
    } giris_t;

    giris_t        fifo [DEPTH];
    giris_t        head;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic [31:0]   fetch_adr;
    durum_t        durum, durum_nxt;
    logic          issue, push, pop;
    logic          unused_pc_bits;

    assign unused_pc_bits = ^yeni_pc[1:0];

    // A redirect overrides both push and pop in the same cycle.
    assign issue = (durum == BOS) && (count < CNT_FULL) && !yonlendir;
    assign push  = (durum == BEKLE) && bellek_hazir && !yonlendir;
    assign pop   = tuket && (count != '0) && !yonlendir;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) durum <= BOS;
        else        durum <= durum_nxt;
    end

    always_comb begin
        durum_nxt = durum;
        case (durum)
            BOS:     if (issue) durum_nxt = BEKLE;
            BEKLE:   if (bellek_hazir)   durum_nxt = BOS;
                     else if (yonlendir) durum_nxt = AT;
            AT:      if (bellek_hazir)   durum_nxt = BOS;
            default: durum_nxt = BOS;
        endcase
    end

    always_comb begin
        bellek_istek = (durum != BOS);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            fetch_adr    <= {RESET_PC[31:2], 2'b00};
            bellek_adres <= '0;
        end else begin
            if (issue) bellek_adres <= fetch_adr;
            if (yonlendir) begin
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                count     <= '0;
                fetch_adr <= {yeni_pc[31:2], 2'b00};
            end else begin
                if (push) begin
                    wr_ptr    <= wr_ptr + 1'b1;
                    fetch_adr <= bellek_adres + 32'd4;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= '{veri: bellek_veri, adres: bellek_adres, err: bellek_hata};
    end

    assign head          = fifo[rd_ptr];
    assign komut_gecerli = (count != '0);
    assign komut         = komut_gecerli ? head.veri  : 32'h0;
    assign komut_pc      = komut_gecerli ? head.adres : 32'h0;
    assign hata          = komut_gecerli & head.err;

endmodule

// File: doc/komut_on_getirme.md
Name: komut_on_getirme

Overview:
- Instruction prefetch buffer sitting directly upstream of the decode/execute core; it supplies the `komut` word the core decodes.
- Fetches sequential instruction words from instruction memory over a req/ack handshake and holds them in a small FIFO.
- Presents the head entry to the core and restarts fetching when the core redirects the PC (branch/jump).

Parameters:
- DEPTH, 4, number of FIFO entries (power of two, 2..16).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- yonlendir  in  1  redirect: flush buffer and restart fetch at yeni_pc.
- yeni_pc  in  32  redirect target; bits [1:0] ignored (treated as 0).
- tuket  in  1  core consumes the head entry this cycle.
- komut  out  32  head instruction word; 0 when buffer empty.
- komut_pc  out  32  address of head instruction; 0 when empty.
- komut_gecerli  out  1  buffer non-empty.
- hata  out  1  head entry was fetched with bus error (only when komut_gecerli=1).
- bellek_istek  out  1  memory request.
- bellek_adres  out  32  request address, word aligned.
- bellek_hazir  in  1  memory ack; bellek_veri/bellek_hata valid this cycle.
- bellek_veri  in  32  returned instruction word.
- bellek_hata  in  1  bus error for this response.

Behaviour:
- Reset (async assert, sync release): FIFO empty, fetch_adr=RESET_PC with [1:0] cleared, state BOS. Outputs: bellek_istek=0, bellek_adres=0, komut=0, komut_pc=0, komut_gecerli=0, hata=0. bellek_istek drops immediately on reset assertion, including mid-request.
- FIFO entry = {veri[31:0], adres[31:0], err}. count in 0..DEPTH.
- FSM states:
  - BOS: no request outstanding.
  - BEKLE: request outstanding.
  - AT: request outstanding; its response will be discarded.
- bellek_istek=1 exactly in BEKLE and AT. bellek_adres is registered and stable while bellek_istek=1.
- BOS -> BEKLE when count<DEPTH and yonlendir=0. On that transition, bellek_adres<=fetch_adr.
- BEKLE on bellek_hazir:
  - Push {bellek_veri, bellek_adres, bellek_hata}.
  - fetch_adr<=bellek_adres+4, wrapping mod 2^32.
  - Go to BOS.
- Throughput: at most one word per 2 cycles. At most one request outstanding.
- A push never overflows: issue requires count<DEPTH, and count cannot grow while BEKLE is pending.
- yonlendir (any state) has priority over tuket and over push in the same cycle:
  - FIFO cleared next cycle.
  - fetch_adr<={yeni_pc[31:2],2'b00}.
  - From BEKLE without bellek_hazir: go to AT.
  - From BEKLE with bellek_hazir: drop the data, go to BOS.
  - From BOS: stay in BOS; the new request issues the following cycle.
  - From AT: stay in AT; fetch_adr is updated.
- AT on bellek_hazir: data and error discarded, go to BOS. No push.
- tuket when empty: ignored. tuket and push in the same cycle: both apply, count unchanged.
- Core outputs are combinational from the head entry: komut_gecerli=(count!=0), hata=head.err & komut_gecerli.
- A bus-errored entry is consumed like any other. Fetching continues at the next address; the core decides what to do with it.

Test Plan:
- Reset release, memory acks 1 cycle after each request with veri=adres^32'hA5A5_A5A5 → requests to 0,4,8,C. Entry 0 appears as komut=32'hA5A5_A5A5, komut_pc=0. Requests stop with count=4 when tuket=0. One tuket → exactly one new request, to 0x10.
- Buffer full, tuket held high, memory ack delay 0 → komut_pc sequence 0,4,8,... with no gaps. No overflow, no duplicate.
- Request to 0x8 pending, yonlendir with yeni_pc=0x103 → FSM enters AT. Buffer empties next cycle. The late 0x8 response is dropped. Next request is to 0x100, and its data appears with komut_pc=0x100.
- yonlendir in the same cycle as bellek_hazir and tuket → nothing pushed, FIFO empty, next request to the target.
- Memory returns bellek_hata=1 for 0x4 → when 0x4 is head, hata=1 and komut_gecerli=1. The 0x8 entry shows hata=0.
- reset pulsed low mid-request → bellek_istek falls immediately. After release, the first request is to RESET_PC.
- Redirect to 32'hFFFF_FFFC → fetches 0xFFFF_FFFC then 0x0 (wrap).
